scalar_id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register of the scalar core, with load-use hazard detection.
- Captures decoded operands, register indices and operand-select controls every cycle.
- Presents them to the ALU forwarding stage, which consumes the R2/R3 values, the R2/R3 indices, ExtndSel and immF.
- Inserts a one-cycle bubble when a load in EX produces a register the decode instruction needs. Also handles branch flush and an external global hold.

---
 rtl/scalar_id_ex_stage.sv | 137 +++++++++++++
 tb/tb_scalar_id_ex_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/scalar_id_ex_stage.sv
// Decode-to-execute pipeline register of the scalar core.
// Detects load-use hazards, inserts one bubble per hazard, and handles flush and global hold.
module scalar_id_ex_stage #(
   parameter int DW   = 32,
   parameter int RW   = 4,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_d,
   input  logic [DW-1:0]   r2val_d,
   input  logic [DW-1:0]   r3val_d,
   input  logic [RW-1:0]   r2_d,
   input  logic [RW-1:0]   r3_d,
   input  logic [RW-1:0]   dest_d,
   input  logic [1:0]      extndsel_d,
   input  logic            immf_d,
   input  logic            memrd_d,
   input  logic            regwr_d,
   input  logic            flush,
   input  logic            hold,
   output logic [DW-1:0]   r2val_e,
   output logic [DW-1:0]   r3val_e,
   output logic [RW-1:0]   r2_e,
   output logic [RW-1:0]   r3_e,
   output logic [1:0]      extndsel_e,
   output logic            immf_e,
   output logic [RW-1:0]   dest_e,
   output logic            memrd_e,
   output logic            regwr_e,
   output logic            valid_e,
   output logic            stall_fd,
   output logic [CNTW-1:0] bubble_cnt
);

   logic            ex_valid_q, ex_valid_d;
   logic            ex_regwr_q, ex_regwr_d;
   logic            ex_memrd_q, ex_memrd_d;
   logic [RW-1:0]   ex_dest_q, ex_dest_d;
   logic [RW-1:0]   ex_r2_q, ex_r2_d;
   logic [RW-1:0]   ex_r3_q, ex_r3_d;
   logic [DW-1:0]   ex_r2val_q, ex_r2val_d;
   logic [DW-1:0]   ex_r3val_q, ex_r3val_d;
   logic [1:0]      ex_extndsel_q, ex_extndsel_d;
   logic            ex_immf_q, ex_immf_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   logic use2, use3, lu;

   // Immediate forms replace R2 (sign/zero-extended imm) or R3 (short imm) as a source.
   assign use2 = (r2_d != '0) & ~(immf_d & extndsel_d[1]);
   assign use3 = (r3_d != '0) & (~immf_d | (extndsel_d == 2'b00));
   assign lu   = ex_valid_q & ex_memrd_q & (ex_dest_q != '0) & valid_d &
                 ((use2 & (r2_d == ex_dest_q)) | (use3 & (r3_d == ex_dest_q)));

   assign stall_fd = hold | (lu & ~flush);

   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_regwr_d    = ex_regwr_q;
      ex_memrd_d    = ex_memrd_q;
      ex_dest_d     = ex_dest_q;
      ex_r2_d       = ex_r2_q;
      ex_r3_d       = ex_r3_q;
      ex_r2val_d    = ex_r2val_q;
      ex_r3val_d    = ex_r3val_q;
      ex_extndsel_d = ex_extndsel_q;
      ex_immf_d     = ex_immf_q;
      cnt_d         = cnt_q;
      if (flush || (!hold && lu)) begin
         // Bubble: dest 0 guarantees forwarding never matches it.
         ex_valid_d    = 1'b0;
         ex_regwr_d    = 1'b0;
         ex_memrd_d    = 1'b0;
         ex_dest_d     = '0;
         ex_r2_d       = '0;
         ex_r3_d       = '0;
         ex_r2val_d    = '0;
         ex_r3val_d    = '0;
         ex_extndsel_d = '0;
         ex_immf_d     = 1'b0;
         if (!flush && cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else if (!hold) begin
         ex_valid_d    = valid_d;
         ex_regwr_d    = valid_d & regwr_d;
         ex_memrd_d    = valid_d & memrd_d;
         ex_dest_d     = valid_d ? dest_d : '0;
         ex_r2_d       = r2_d;
         ex_r3_d       = r3_d;
         ex_r2val_d    = r2val_d;
         ex_r3val_d    = r3val_d;
         ex_extndsel_d = extndsel_d;
         ex_immf_d     = immf_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid_q    <= 1'b0;
         ex_regwr_q    <= 1'b0;
         ex_memrd_q    <= 1'b0;
         ex_dest_q     <= '0;
         ex_r2_q       <= '0;
         ex_r3_q       <= '0;
         ex_r2val_q    <= '0;
         ex_r3val_q    <= '0;
         ex_extndsel_q <= '0;
         ex_immf_q     <= 1'b0;
         cnt_q         <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_regwr_q    <= ex_regwr_d;
         ex_memrd_q    <= ex_memrd_d;
         ex_dest_q     <= ex_dest_d;
         ex_r2_q       <= ex_r2_d;
         ex_r3_q       <= ex_r3_d;
         ex_r2val_q    <= ex_r2val_d;
         ex_r3val_q    <= ex_r3val_d;
         ex_extndsel_q <= ex_extndsel_d;
         ex_immf_q     <= ex_immf_d;
         cnt_q         <= cnt_d;
      end
   end

   assign valid_e    = ex_valid_q;
   assign regwr_e    = ex_regwr_q;
   assign memrd_e    = ex_memrd_q;
   assign dest_e     = ex_dest_q;
   assign r2_e       = ex_r2_q;
   assign r3_e       = ex_r3_q;
   assign r2val_e    = ex_r2val_q;
   assign r3val_e    = ex_r3val_q;
   assign extndsel_e = ex_extndsel_q;
   assign immf_e     = ex_immf_q;
   assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_scalar_id_ex_stage.sv
// Directed bench for scalar_id_ex_stage: expected EX state queued per step, compared after each edge.
module tb_scalar_id_ex_stage;

   localparam int DW   = 32;
   localparam int RW   = 4;
   localparam int CNTW = 6;

   typedef struct packed {
      logic            valid;
      logic            regwr;
      logic            memrd;
      logic [RW-1:0]   dest;
      logic [RW-1:0]   r2;
      logic [RW-1:0]   r3;
      logic [DW-1:0]   r2v;
      logic [DW-1:0]   r3v;
      logic [1:0]      es;
      logic            immf;
      logic [CNTW-1:0] cnt;
   } ex_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            valid_d, immf_d, memrd_d, regwr_d, flush, hold;
   logic [DW-1:0]   r2val_d, r3val_d;
   logic [RW-1:0]   r2_d, r3_d, dest_d;
   logic [1:0]      extndsel_d;
   logic [DW-1:0]   r2val_e, r3val_e;
   logic [RW-1:0]   r2_e, r3_e, dest_e;
   logic [1:0]      extndsel_e;
   logic            immf_e, memrd_e, regwr_e, valid_e, stall_fd;
   logic [CNTW-1:0] bubble_cnt;

   int unsigned     checks = 0;
   int unsigned     passed = 0;
   logic [CNTW-1:0] exp_cnt = '0;
   ex_t             sb[$];
   ex_t             last_exp;

   scalar_id_ex_stage #(.DW(DW), .RW(RW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .valid_d(valid_d), .r2val_d(r2val_d), .r3val_d(r3val_d),
      .r2_d(r2_d), .r3_d(r3_d), .dest_d(dest_d), .extndsel_d(extndsel_d), .immf_d(immf_d),
      .memrd_d(memrd_d), .regwr_d(regwr_d), .flush(flush), .hold(hold),
      .r2val_e(r2val_e), .r3val_e(r3val_e), .r2_e(r2_e), .r3_e(r3_e),
      .extndsel_e(extndsel_e), .immf_e(immf_e), .dest_e(dest_e), .memrd_e(memrd_e),
      .regwr_e(regwr_e), .valid_e(valid_e), .stall_fd(stall_fd), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   function automatic ex_t mk(input logic v, rw, md, input logic [RW-1:0] d, a, b,
                              input logic [DW-1:0] av, bv, input logic [1:0] es, input logic im);
      mk = '{valid:v, regwr:rw, memrd:md, dest:d, r2:a, r3:b, r2v:av, r3v:bv, es:es, immf:im, cnt:'0};
   endfunction

   function automatic ex_t obs();
      obs = '{valid:valid_e, regwr:regwr_e, memrd:memrd_e, dest:dest_e, r2:r2_e, r3:r3_e,
              r2v:r2val_e, r3v:r3val_e, es:extndsel_e, immf:immf_e, cnt:bubble_cnt};
   endfunction

   task automatic drv(input logic v, input logic [RW-1:0] a, b, d, input logic [DW-1:0] av, bv,
                      input logic [1:0] es, input logic im, md, rw);
      valid_d = v; r2_d = a; r3_d = b; dest_d = d; r2val_d = av; r3val_d = bv;
      extndsel_d = es; immf_d = im; memrd_d = md; regwr_d = rw;
   endtask

   task automatic chk_stall(input logic exp, input string tag);
      checks++;
      assert (stall_fd === exp) passed++;
      else $error("FAIL %s stall_fd got=%b want=%b", tag, stall_fd, exp);
   endtask

   task automatic chk_ex(input ex_t e, input string tag);
      ex_t o;
      o = obs();
      checks++;
      assert (o === e) passed++;
      else $error("FAIL %s ex got=%h want=%h", tag, o, e);
   endtask

   // Inputs already driven: check stall, queue expected EX state, clock, compare.
   task automatic cycle(input logic exp_stall, input ex_t e, input string tag);
      ex_t x;
      #1;
      chk_stall(exp_stall, tag);
      e.cnt = exp_cnt;
      sb.push_back(e);
      last_exp = e;
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk_ex(x, tag);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; hold = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 rst = 1'b0;
      #2 chk_ex(mk(0,0,0,0,0,0,0,0,0,0), "reset_init");
      @(posedge clk); #1 rst = 1'b1;

      drv(1, 3, 4, 7, 32'h11, 32'h22, 2'b00, 0, 0, 1);
      cycle(0, mk(1,1,0,7,3,4,32'h11,32'h22,2'b00,0), "pass_through");

      drv(1, 1, 2, 6, 32'hA, 32'hB, 2'b00, 0, 1, 1);
      cycle(0, mk(1,1,1,6,1,2,32'hA,32'hB,2'b00,0), "load_capture");

      drv(1, 0, 6, 8, 32'h33, 32'h44, 2'b00, 0, 0, 1);
      exp_cnt = 1;
      cycle(1, mk(0,0,0,0,0,0,0,0,0,0), "lu_bubble");
      cycle(0, mk(1,1,0,8,0,6,32'h33,32'h44,2'b00,0), "lu_release");

      drv(1, 0, 0, 6, 32'h1, 32'h2, 2'b00, 0, 1, 1);
      cycle(0, mk(1,1,1,6,0,0,32'h1,32'h2,2'b00,0), "load_again");
      drv(1, 0, 6, 6, 32'h3, 32'h4, 2'b01, 1, 1, 1);
      cycle(0, mk(1,1,1,6,0,6,32'h3,32'h4,2'b01,1), "imm_mask_r3");
      drv(1, 6, 0, 6, 32'h5, 32'h6, 2'b10, 1, 1, 1);
      cycle(0, mk(1,1,1,6,6,0,32'h5,32'h6,2'b10,1), "imm_mask_r2");
      drv(1, 6, 0, 6, 32'h7, 32'h8, 2'b01, 1, 1, 1);
      exp_cnt = 2;
      cycle(1, mk(0,0,0,0,0,0,0,0,0,0), "imm01_uses_r2");
      cycle(0, mk(1,1,1,6,6,0,32'h7,32'h8,2'b01,1), "imm01_release");

      drv(1, 0, 6, 9, 32'h9, 32'h9, 2'b00, 0, 0, 1);
      flush = 1'b1;
      cycle(0, mk(0,0,0,0,0,0,0,0,0,0), "flush_vs_lu");
      flush = 1'b0;

      drv(1, 1, 2, 6, 32'h1, 32'h2, 2'b00, 0, 1, 1);
      cycle(0, mk(1,1,1,6,1,2,32'h1,32'h2,2'b00,0), "load_pre_hold");
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 6, 10, 32'h100 + i, 32'h200 + i, 2'(i), 0, 0, 1);
         cycle(1, last_exp, "hold_freeze");
      end
      flush = 1'b1;
      cycle(1, mk(0,0,0,0,0,0,0,0,0,0), "flush_over_hold");
      flush = 1'b0; hold = 1'b0;

      drv(0, 5, 5, 9, 32'h55, 32'h55, 2'b11, 1, 1, 1);
      cycle(0, mk(0,0,0,0,5,5,32'h55,32'h55,2'b11,1), "invalid_capture");

      drv(1, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 1, 0);
      cycle(0, mk(1,0,1,0,0,0,0,0,2'b00,0), "load_dest0");
      drv(1, 0, 0, 3, 32'h12, 32'h34, 2'b00, 0, 0, 1);
      cycle(0, mk(1,1,0,3,0,0,32'h12,32'h34,2'b00,0), "no_lu_dest0");

      drv(1, 0, 0, 6, 32'h1, 32'h1, 2'b00, 0, 1, 1);
      cycle(0, mk(1,1,1,6,0,0,32'h1,32'h1,2'b00,0), "load_pre_invalid");
      drv(0, 6, 6, 4, 32'h2, 32'h3, 2'b00, 0, 0, 1);
      cycle(0, mk(0,0,0,0,6,6,32'h2,32'h3,2'b00,0), "no_lu_invalid_d");

      drv(1, 0, 0, 6, 32'h1, 32'h1, 2'b00, 0, 1, 1);
      cycle(0, mk(1,1,1,6,0,0,32'h1,32'h1,2'b00,0), "load_pre_reset");
      drv(1, 6, 0, 6, 32'hC, 32'hD, 2'b00, 0, 1, 1);
      #1 chk_stall(1, "stall_pre_reset");
      rst = 1'b0;
      exp_cnt = '0;
      #1 chk_ex(mk(0,0,0,0,0,0,0,0,0,0), "reset_midstall");
      chk_stall(0, "reset_stall_clear");
      #1 rst = 1'b1;
      cycle(0, mk(1,1,1,6,6,0,32'hC,32'hD,2'b00,0), "post_reset_capture");

      // Chained dependent loads: every pair costs one bubble until the counter saturates.
      for (int i = 0; i < (1 << CNTW) + 1; i++) begin
         drv(1, 6, 0, 6, 32'(i), 32'hF0, 2'b00, 0, 1, 1);
         if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
         cycle(1, mk(0,0,0,0,0,0,0,0,0,0), "sat_bubble");
         cycle(0, mk(1,1,1,6,6,0,32'(i),32'hF0,2'b00,0), "sat_capture");
      end
      checks++;
      assert (bubble_cnt === {CNTW{1'b1}}) passed++;
      else $error("FAIL saturate bubble_cnt got=%h want=%h", bubble_cnt, {CNTW{1'b1}});

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
